// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and state encoding for the limb-serial wide adder/subtractor.
package wide_add_seq_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// 32-bit carry-select adder: low half ripples, high half is precomputed for both carries.
module CSA_ADDER
  import wide_add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int HW = WORD_W / 2;

  logic [HW:0] lo;
  logic [HW:0] hi0;
  logic [HW:0] hi1;

  always_comb begin
    lo  = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + {{HW{1'b0}}, cin};
    hi0 = {1'b0, a[WORD_W-1:HW]} + {1'b0, b[WORD_W-1:HW]};
    hi1 = {1'b0, a[WORD_W-1:HW]} + {1'b0, b[WORD_W-1:HW]} + {{HW{1'b0}}, 1'b1};
    sum  = {(lo[HW] ? hi1[HW-1:0] : hi0[HW-1:0]), lo[HW-1:0]};
    cout = lo[HW] ? hi1[HW] : hi0[HW];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract, one 32-bit limb per cycle, LSB limb first.
// Define WIDE_ADD_SEQ_OVF_EN to register signed overflow; otherwise out_ovf is 0.
module wide_add_sequencer
  import wide_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_a,
  input  logic [WORDS*WORD_W-1:0] in_b,
  input  logic                    in_cin,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf
);

  localparam int W  = WORDS * WORD_W;
  localparam int IW = $clog2(WORDS);

  state_t            state;
  state_t            state_nxt;
  logic [W-1:0]      opa;
  logic [W-1:0]      opb;
  logic              carry;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] limb_a;
  logic [WORD_W-1:0] limb_b;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic              last;

  assign last   = (idx == IW'(WORDS - 1));
  assign limb_a = opa[int'(idx)*WORD_W +: WORD_W];
  assign limb_b = opb[int'(idx)*WORD_W +: WORD_W];

  CSA_ADDER u_adder (
    .a    (limb_a),
    .b    (limb_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= in_a;
            opb   <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? 1'b1 : in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          out_sum[int'(idx)*WORD_W +: WORD_W] <= add_sum;
          carry <= add_cout;
          if (last) begin
            out_cout  <= add_cout;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef WIDE_ADD_SEQ_OVF_EN
  // opb is already inverted for subtract, so one rule covers both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (state == RUN && last) begin
      out_ovf <= (opa[W-1] == opb[W-1]) && (add_sum[WORD_W-1] != opa[W-1]);
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule
